// File: rtl/outsig_pkg.sv
// Shared types, MISR constants and the output-bus fold helper for out_sig_collector.
package outsig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  // Widest observed bus the fold helper accepts; narrower buses are zero-padded.
  localparam int FOLD_MAX_W = 1024;

  function automatic logic [31:0] fold_chunks(input logic [FOLD_MAX_W-1:0] data);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
      acc = acc ^ data[i*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/out_sig_collector_if.sv
// Result stream of out_sig_collector: valid/ready handshake carrying 32-bit words.
interface out_sig_collector_if;
  logic        sig_valid;
  logic        sig_ready;
  logic [31:0] sig_data;
  logic        sig_last;

  modport master (output sig_valid, output sig_data, output sig_last, input sig_ready);
  modport slave  (input sig_valid, input sig_data, input sig_last, output sig_ready);
endinterface

// File: rtl/outsig_misr.sv
// 32-bit CRC-style MISR: seeded on clear, folds din into the signature when en is high.
module outsig_misr
  import outsig_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ din;
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/out_sig_collector.sv
// Compresses a DUT output bus into a MISR signature over a run, then streams the result words.
// Optional OUTSIG_CHANGE_CNT_EN adds a change counter emitted as a third word.
module out_sig_collector
  import outsig_pkg::*;
#(
  parameter int OUT_W = 159,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    cycles,
  input  logic [OUT_W-1:0]    out_flat,
  out_sig_collector_if.master strm,
  output logic                busy,
  output logic                done
);

`ifdef OUTSIG_CHANGE_CNT_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [1:0]          word_idx_q, word_idx_d;
  logic                sig_valid_q, sig_valid_d;
  logic [31:0]         sig_data_q, sig_data_d;
  logic                sig_last_q, sig_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef OUTSIG_CHANGE_CNT_EN
  logic [OUT_W-1:0]    prev_q, prev_d;
  logic [CNT_W-1:0]    chg_cnt_q, chg_cnt_d;
`endif

  logic                   start_s, run_last_s, accept_s;
  logic                   misr_clear_s, misr_en_s;
  logic [FOLD_MAX_W-1:0]  flat_ext_s;
  logic [31:0]            fold_s, misr_sig_s, sel_word_s;
  logic [1:0]             sel_idx_s;

  assign start_s    = (state_q == ST_IDLE) && start;
  assign run_last_s = (state_q == ST_RUN) && (sample_cnt_q == (cycles_q - CNT_ONE));
  assign accept_s   = sig_valid_q && strm.sig_ready;

  always_comb begin
    flat_ext_s = '0;
    flat_ext_s[OUT_W-1:0] = out_flat;
    fold_s = fold_chunks(flat_ext_s);
  end

  outsig_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (misr_clear_s),
    .en    (misr_en_s),
    .din   (fold_s),
    .sig   (misr_sig_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = (cycles == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:   state_d = run_last_s ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = (accept_s && sig_last_q) ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First DRAIN cycle loads the current word; afterwards each accept advances to the next.
  always_comb begin
    sel_idx_s = sig_valid_q ? (word_idx_q + 2'd1) : word_idx_q;
    case (sel_idx_s)
      2'd0:    sel_word_s = misr_sig_s;
      2'd1:    sel_word_s = 32'(sample_cnt_q);
`ifdef OUTSIG_CHANGE_CNT_EN
      2'd2:    sel_word_s = 32'(chg_cnt_q);
`endif
      default: sel_word_s = 32'h0;
    endcase
  end

  always_comb begin
    cycles_d     = cycles_q;
    sample_cnt_d = sample_cnt_q;
    word_idx_d   = word_idx_q;
    sig_valid_d  = sig_valid_q;
    sig_data_d   = sig_data_q;
    sig_last_d   = sig_last_q;
    done_d       = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    misr_clear_s = 1'b0;
    misr_en_s    = 1'b0;
`ifdef OUTSIG_CHANGE_CNT_EN
    prev_d       = prev_q;
    chg_cnt_d    = chg_cnt_q;
`endif
    if (start_s) begin
      cycles_d     = cycles;
      sample_cnt_d = '0;
      word_idx_d   = 2'd0;
      misr_clear_s = 1'b1;
`ifdef OUTSIG_CHANGE_CNT_EN
      prev_d       = '0;
      chg_cnt_d    = '0;
`endif
    end else if (state_q == ST_RUN) begin
      misr_en_s    = 1'b1;
      sample_cnt_d = sample_cnt_q + CNT_ONE;
`ifdef OUTSIG_CHANGE_CNT_EN
      prev_d       = out_flat;
      chg_cnt_d    = (out_flat != prev_q) ? (chg_cnt_q + CNT_ONE) : chg_cnt_q;
`endif
    end else if (state_q == ST_DRAIN) begin
      if (!sig_valid_q) begin
        sig_valid_d = 1'b1;
        sig_data_d  = sel_word_s;
        sig_last_d  = (sel_idx_s == LAST_IDX);
      end else if (accept_s && sig_last_q) begin
        sig_valid_d = 1'b0;
        sig_data_d  = 32'h0;
        sig_last_d  = 1'b0;
        done_d      = 1'b1;
      end else if (accept_s) begin
        word_idx_d  = sel_idx_s;
        sig_data_d  = sel_word_s;
        sig_last_d  = (sel_idx_s == LAST_IDX);
      end else begin
        sig_valid_d = sig_valid_q;
      end
    end else begin
      busy_d = (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q     <= '0;
      sample_cnt_q <= '0;
      word_idx_q   <= 2'd0;
      sig_valid_q  <= 1'b0;
      sig_data_q   <= 32'h0;
      sig_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef OUTSIG_CHANGE_CNT_EN
      prev_q       <= '0;
      chg_cnt_q    <= '0;
`endif
    end else begin
      cycles_q     <= cycles_d;
      sample_cnt_q <= sample_cnt_d;
      word_idx_q   <= word_idx_d;
      sig_valid_q  <= sig_valid_d;
      sig_data_q   <= sig_data_d;
      sig_last_q   <= sig_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef OUTSIG_CHANGE_CNT_EN
      prev_q       <= prev_d;
      chg_cnt_q    <= chg_cnt_d;
`endif
    end
  end

  assign strm.sig_valid = sig_valid_q;
  assign strm.sig_data  = sig_data_q;
  assign strm.sig_last  = sig_last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
